// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants used by decode and by the multiply
// sequencer, plus the sequencer's state type.
package alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SLL   = 4'b0001;
    localparam logic [3:0] ALU_SLT   = 4'b0010;
    localparam logic [3:0] ALU_SLTU  = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SRL   = 4'b0101;
    localparam logic [3:0] ALU_OR    = 4'b0110;
    localparam logic [3:0] ALU_AND   = 4'b0111;
    localparam logic [3:0] ALU_SUB   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1101;
    localparam logic [3:0] ALU_PASS2 = 4'b1110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-and-add 32x32 multiplier (low half) that borrows the execute-stage ALU's ADD.
// Define ALU_MUL_SEQ_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [XLEN-1:0] start_a,
    input  logic [XLEN-1:0] start_b,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [XLEN-1:0] res_data,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic [3:0]      ex_func,
    output logic            ex_alu_grant,
    output logic [XLEN-1:0] alu_rs1,
    output logic [XLEN-1:0] alu_rs2,
    output logic [3:0]      alu_func,
    input  logic [XLEN-1:0] alu_out
);

    localparam int CNT_W = $clog2(XLEN);

    mul_state_e      state_q, state_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            res_valid_q, res_valid_d;
    logic [XLEN-1:0] res_data_q, res_data_d;
    logic            calc_last;

`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
    assign calc_last = (cnt_q == CNT_W'(XLEN - 1)) || (mplier_q[XLEN-1:1] == '0);
`else
    assign calc_last = (cnt_q == CNT_W'(XLEN - 1));
`endif

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        state_d     = state_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;

        if (flush) begin
            // Abort leaves the datapath alone; only control and the valid flag are cleared.
            state_d     = ST_IDLE;
            res_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_valid) begin
                        mcand_d  = start_a;
                        mplier_d = start_b;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (mplier_q[0]) begin
                        acc_d = alu_out;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (calc_last) begin
                        state_d     = ST_DONE;
                        res_valid_d = 1'b1;
                        res_data_d  = acc_d;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state_d     = ST_IDLE;
                        res_valid_d = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    assign start_ready = (state_q == ST_IDLE) && !flush;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;

    always_comb begin
        ex_alu_grant = 1'b1;
        alu_rs1      = ex_rs1;
        alu_rs2      = ex_rs2;
        alu_func     = ex_func;
        if (state_q == ST_CALC) begin
            ex_alu_grant = 1'b0;
            alu_rs1      = acc_q;
            alu_rs2      = mcand_q;
            alu_func     = ALU_ADD;
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: directed and random multiplies against an
// arithmetic reference, with a behavioural ALU closing the loop.
module tb_alu_mul_seq;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        start_valid;
    logic        start_ready;
    logic [31:0] start_a;
    logic [31:0] start_b;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [31:0] ex_rs1;
    logic [31:0] ex_rs2;
    logic [3:0]  ex_func;
    logic        ex_alu_grant;
    logic [31:0] alu_rs1;
    logic [31:0] alu_rs2;
    logic [3:0]  alu_func;
    logic [31:0] alu_out;

    int n_vec = 0;
    int n_err = 0;

    alu_mul_seq #(.XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .start_a     (start_a),
        .start_b     (start_b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .ex_rs1      (ex_rs1),
        .ex_rs2      (ex_rs2),
        .ex_func     (ex_func),
        .ex_alu_grant(ex_alu_grant),
        .alu_rs1     (alu_rs1),
        .alu_rs2     (alu_rs2),
        .alu_func    (alu_func),
        .alu_out     (alu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stand-in for the execute-stage ALU.
    always_comb begin
        alu_out = alu_rs1 ^ alu_rs2;
        case (alu_func)
            ALU_ADD:   alu_out = alu_rs1 + alu_rs2;
            ALU_SUB:   alu_out = alu_rs1 - alu_rs2;
            ALU_PASS2: alu_out = alu_rs2;
            default:   alu_out = alu_rs1 ^ alu_rs2;
        endcase
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed hang, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] full;
        full = {32'd0, a} * {32'd0, b};
        return full[31:0];
    endfunction

    // Accumulator expected after k shift-add steps: a times the k low bits of b.
    function automatic logic [31:0] ref_partial(input logic [31:0] a, input logic [31:0] b, input int k);
        logic [63:0] mask;
        logic [63:0] full;
        mask = (64'd1 << k) - 64'd1;
        full = {32'd0, a} * ({32'd0, b} & mask);
        return full[31:0];
    endfunction

    function automatic int calc_len(input logic [31:0] b);
`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
        int h;
        h = 0;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) h = i;
        end
        return h + 1;
`else
        return 32 + 0 * int'(b[0]);
`endif
    endfunction

    task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] exp_p;
        logic [31:0] exp_acc;
        logic [31:0] exp_mcand;
        int          calc_seen;
        bit          done;
        exp_p     = ref_mul(a, b);
        calc_seen = 0;
        done      = 1'b0;
        @(negedge clk);
        start_valid = 1'b1;
        start_a     = a;
        start_b     = b;
        res_ready   = 1'b0;
        #1 check("start_ready_idle", 32'(start_ready), 32'd1);
        @(negedge clk);
        start_valid = 1'b0;
        start_a     = $urandom;
        start_b     = $urandom;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            ex_rs1  = $urandom;
            ex_rs2  = $urandom;
            ex_func = ALU_SUB;
            #1;
            if (res_valid) begin
                done = 1'b1;
            end else begin
                exp_acc   = ref_partial(a, b, calc_seen);
                exp_mcand = a << calc_seen;
                check("calc_grant", 32'(ex_alu_grant), 32'd0);
                check("calc_func", 32'(alu_func), 32'(ALU_ADD));
                check("calc_rs1_acc", alu_rs1, exp_acc);
                check("calc_rs2_mcand", alu_rs2, exp_mcand);
                calc_seen++;
                @(negedge clk);
            end
        end
        if (!done) begin
            check("res_valid_timeout", 32'(res_valid), 32'd1);
        end else begin
            check("calc_len", 32'(calc_seen), 32'(calc_len(b)));
            check("res_data", res_data, exp_p);
            check("done_grant", 32'(ex_alu_grant), 32'd1);
            check("done_start_ready", 32'(start_ready), 32'd0);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                #1;
                check("hold_valid", 32'(res_valid), 32'd1);
                check("hold_data", res_data, exp_p);
                check("hold_start_ready", 32'(start_ready), 32'd0);
            end
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            #1;
            check("after_valid", 32'(res_valid), 32'd0);
            check("after_start_ready", 32'(start_ready), 32'd1);
            check("after_grant", 32'(ex_alu_grant), 32'd1);
        end
    endtask

    task automatic abort_run(input logic [31:0] a, input logic [31:0] b, input int at_cyc, input bit use_rst);
        int bad;
        bad = 0;
        @(negedge clk);
        start_valid = 1'b1;
        start_a     = a;
        start_b     = b;
        #1 check("abort_start_ready", 32'(start_ready), 32'd1);
        @(negedge clk);
        start_valid = 1'b0;
        repeat (at_cyc) @(negedge clk);
        #1 check("abort_in_calc", 32'(ex_alu_grant), 32'd0);
        start_valid = 1'b1;
        start_a     = $urandom;
        start_b     = $urandom;
        if (use_rst) begin
            rst_n = 1'b0;
        end else begin
            flush = 1'b1;
            #1 check("flush_blocks_start", 32'(start_ready), 32'd0);
        end
        @(negedge clk);
        flush       = 1'b0;
        rst_n       = 1'b1;
        start_valid = 1'b0;
        #1;
        check("abort_idle_grant", 32'(ex_alu_grant), 32'd1);
        check("abort_idle_ready", 32'(start_ready), 32'd1);
        check("abort_no_valid", 32'(res_valid), 32'd0);
        if (use_rst) check("abort_rst_data", res_data, 32'd0);
        repeat (40) begin
            @(negedge clk);
            #1;
            if (res_valid || !ex_alu_grant) bad++;
        end
        check("abort_quiet", 32'(bad), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        rst_n       = 1'b0;
        flush       = 1'b0;
        start_valid = 1'b0;
        start_a     = '0;
        start_b     = '0;
        res_ready   = 1'b0;
        ex_rs1      = '0;
        ex_rs2      = '0;
        ex_func     = ALU_ADD;
        repeat (3) @(negedge clk);
        #1;
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_start_ready", 32'(start_ready), 32'd1);
        check("rst_grant", 32'(ex_alu_grant), 32'd1);
        rst_n = 1'b1;

        @(negedge clk);
        ex_rs1  = 32'h10;
        ex_rs2  = 32'h20;
        ex_func = ALU_SUB;
        #1;
        check("pass_rs1", alu_rs1, 32'h10);
        check("pass_rs2", alu_rs2, 32'h20);
        check("pass_func", 32'(alu_func), 32'(ALU_SUB));
        check("pass_alu_out", alu_out, 32'hFFFF_FFF0);

        do_mul(32'd3, 32'd5, 0);
        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_mul(32'h8000_0000, 32'd2, 0);
        do_mul(32'd7, 32'd6, 10);
        do_mul(32'd9, 32'h10, 0);
        do_mul(32'hDEAD_BEEF, 32'd0, 1);

        abort_run(32'd1234, 32'h8000_0123, 10, 1'b0);
        do_mul(32'd1234, 32'd5678, 0);
        abort_run(32'hCAFE_F00D, 32'h8765_4321, 20, 1'b1);
        do_mul(32'hCAFE_F00D, 32'h8765_4321, 2);

        for (int i = 0; i < 10; i++) begin
            a = $urandom;
            b = $urandom;
            b = b >> $urandom_range(0, 31);
            do_mul(a, b, $urandom_range(0, 3));
        end

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ex_rs1  = $urandom;
            ex_rs2  = $urandom;
            ex_func = ALU_PASS2;
            #1;
            check("rand_pass_rs1", alu_rs1, ex_rs1);
            check("rand_pass_rs2", alu_rs2, ex_rs2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Iterative 32x32 multiply sequencer (low 32 bits of the product) built on the existing combinational ALU's ADD operation, so no separate multiplier array is needed.
- Sits beside the execute stage and owns the mux in front of the ALU inputs.
  - When idle, the execute stage's ALU operands pass straight through.
  - While a multiply is running, the sequencer drives the ALU and stalls the execute stage's ALU use.

Parameters:
- XLEN, 32, operand/result width (only 32 supported; counter sized $clog2(XLEN)).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- flush  input  1  synchronous abort of an in-flight multiply.
- start_valid  input  1  multiply request.
- start_ready  output  1  request accepted when valid&ready.
- start_a  input  XLEN  multiplicand.
- start_b  input  XLEN  multiplier.
- res_valid  output  1  product available.
- res_ready  input  1  consumer takes product.
- res_data  output  XLEN  low XLEN bits of a*b.
- ex_rs1  input  XLEN  execute-stage ALU operand 1.
- ex_rs2  input  XLEN  execute-stage ALU operand 2.
- ex_func  input  4  execute-stage ALU opcode.
- ex_alu_grant  output  1  1 = ALU currently carries the execute-stage operation.
- alu_rs1  output  XLEN  to ALU rs1.
- alu_rs2  output  XLEN  to ALU rs2.
- alu_func  output  4  to ALU func.
- alu_out  input  XLEN  from ALU ALUout.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n, sampled at posedge clk.
- Reset values: state=IDLE, acc=0, mcand=0, mplier=0, cnt=0, res_valid=0, res_data=0, start_ready=1, ex_alu_grant=1.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid: mcand<=start_a, mplier<=start_b, acc<=0, cnt<=0, go to CALC.
- CALC: each cycle the sequencer drives alu_rs1=acc, alu_rs2=mcand, alu_func=4'b0000 (ADD).
  - if mplier[0], acc<=alu_out.
  - mcand<=mcand<<1; mplier<=mplier>>1; cnt<=cnt+1.
  - When cnt==XLEN-1, go to DONE.
- DONE:
  - res_valid=1, res_data=acc (registered, stable while waiting).
  - On res_ready, go to IDLE next cycle.
  - start_ready=0 in DONE, so there is no same-cycle restart.
- Latency: request accepted at edge T, CALC occupies T+1..T+32, res_valid asserted from T+33. Throughput is one multiply per 34 cycles minimum.
- Arithmetic: all adds are mod 2^XLEN and carries are discarded. The result equals (a*b) mod 2^32 for both signed and unsigned interpretations.
- ALU mux:
  - In CALC: alu_* = sequencer values and ex_alu_grant=0.
  - In IDLE and DONE: alu_* = ex_* and ex_alu_grant=1.
  - The mux is purely combinational from state.
- flush:
  - Takes priority over every other transition in every state: next state IDLE, res_valid<=0, datapath registers untouched.
  - A start_valid in the same cycle as flush is not accepted (start_ready=0 when flush=1).
- rst_n low mid-CALC or in DONE: all registers return to reset values and the result is lost.
- Back-pressure: res_valid stays high and res_data stays constant until res_ready is high.

Optional Feature:
- Macro: ALU_MUL_SEQ_EARLY_EXIT_EN.
- When defined: in CALC, the FSM also goes to DONE when (mplier>>1)==0.
  - Let h be the index of the highest set bit of b. CALC lasts h+1 cycles and res_valid asserts at T+h+2.
  - b=0 gives res_valid at T+2 with result 0.
- When undefined: fixed 32-cycle CALC as specified above. The cnt logic is always present.

Decomposition:
- Shared package alu_pkg:
  - ALU opcode constants (ALU_ADD=4'b0000, ALU_SUB=4'b1000, ALU_SLL=4'b0001, ALU_PASS2=4'b1110, ...), reused by decode and by this block.
  - State typedef for IDLE/CALC/DONE.
- Single module, no sub-module. The ALU instance stays outside, in the execute stage.

Test Plan:
- Basic: a=3, b=5, res_ready=1. Expect res_valid at T+33 with res_data=15, and ex_alu_grant=0 for exactly 32 cycles.
- Wrap/signed: a=0xFFFFFFFF, b=0xFFFFFFFF gives 0x00000001. a=0x80000000, b=2 gives 0x00000000.
- Back-pressure: a=7, b=6, res_ready=0 for 10 cycles after res_valid. Expect res_data=42 held constant and start_ready=0; IDLE one cycle after res_ready=1.
- Pass-through: in IDLE drive ex_rs1=0x10, ex_rs2=0x20, ex_func=4'b1000. Expect alu_rs1/alu_rs2/alu_func to equal them. During CALC expect alu_func=4'b0000 and alu_rs1=acc.
- Abort: flush at CALC cycle 10 (with start_valid=1 in the same cycle), and separately rst_n=0 at cycle 20. Both cases: IDLE next cycle, res_valid never asserts, request not accepted. A new request then computes correctly.
- Early exit (macro defined): b=0x10, a=9. Expect res_valid at T+6, res_data=0x90. b=0: res_valid at T+2, res_data=0.
